// File: rtl/shared_mem_ctrl_if.sv
// Bundle of core request, arbiter and shared-memory signals around shared_mem_ctrl.
// slave is the controller's view; master is the cores/arbiter/memory side.
interface shared_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [2:0]             core_req;
  logic [2:0]             core_we;
  logic [2:0][ADDR_W-1:0] core_addr;
  logic [2:0][DATA_W-1:0] core_wdata;
  logic [2:0]             arb_req;
  logic [2:0]             gnt_arb;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic [2:0]             core_ack;
  logic [DATA_W-1:0]      core_rdata;
  logic                   busy;
  logic [1:0]             owner;
  logic                   grant_err;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, gnt_arb, mem_rdata,
    output arb_req, mem_en, mem_we, mem_addr, mem_wdata, core_ack, core_rdata,
           busy, owner, grant_err
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, gnt_arb, mem_rdata,
    input  arb_req, mem_en, mem_we, mem_addr, mem_wdata, core_ack, core_rdata,
           busy, owner, grant_err
  );
endinterface

// File: rtl/shared_mem_ctrl.sv
// Shared single-port memory controller: samples the arbiter grant once per transaction,
// performs one memory access for the owning core and returns a one-cycle acknowledge.
module shared_mem_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  shared_mem_ctrl_if.slave bus
);

  localparam int unsigned NCORE = 3;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned OWN_W = 2;
  localparam logic [OWN_W-1:0] NO_OWNER = OWN_W'(3);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    lat_cnt;
  logic [OWN_W-1:0]    owner_q;
  logic [OWN_W-1:0]    sel;
  logic [NCORE-1:0]    qual;
  logic                multi_gnt;
  logic [NCORE-1:0]    ack_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                grant_err_q;

  // Only grant bits backed by a live request count.
  assign qual      = bus.core_req & bus.gnt_arb;
  assign multi_gnt = (qual & (qual - NCORE'(1))) != '0;

  // Lowest qualified index wins when the arbiter misbehaves.
  always_comb begin
    sel = '0;
    if (qual[0])      sel = OWN_W'(0);
    else if (qual[1]) sel = OWN_W'(1);
    else if (qual[2]) sel = OWN_W'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      owner_q     <= NO_OWNER;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      ack_q       <= '0;
      grant_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (qual != '0) begin
            state       <= ACCESS;
            owner_q     <= sel;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.core_we[sel];
            mem_addr_q  <= bus.core_addr[sel];
            mem_wdata_q <= bus.core_wdata[sel];
            grant_err_q <= multi_gnt;
          end
        end
        ACCESS: begin
          // mem_we_q still holds the latched direction during ACCESS.
          if (mem_we_q) begin
            state <= RESP;
            ack_q <= NCORE'(1) << owner_q;
          end else begin
            state   <= WAIT;
            lat_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(MEM_LAT)) begin
            rdata_q <= bus.mem_rdata;
            state   <= RESP;
            ack_q   <= NCORE'(1) << owner_q;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          owner_q <= NO_OWNER;
          busy_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Ownership is locked: any grant seen while busy is a protocol error only.
      if (state != IDLE && bus.gnt_arb != '0) grant_err_q <= 1'b1;
    end
  end

  assign bus.arb_req    = (state == IDLE) ? bus.core_req : '0;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_ack   = ack_q;
  assign bus.core_rdata = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;
  assign bus.grant_err  = grant_err_q;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Self-checking bench for shared_mem_ctrl: memory/arbiter models plus a reference memory
// and transaction-level timing rules; extra MEM_LAT=1 and MEM_LAT=7 instances.
module tb_shared_mem_ctrl;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  logic use_force;
  logic [2:0] force_gnt;
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem  [256];
  logic [31:0] init_mem [256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  shared_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  shared_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
  shared_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) b7 ();

  shared_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(L)) dut    (.clk(clk), .rst(rst), .bus(bus));
  shared_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut_l1 (.clk(clk), .rst(rst), .bus(b1));
  shared_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(7)) dut_l7 (.clk(clk), .rst(rst), .bus(b7));

  // Memory models: read data is valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] mem7 [256];
  int age0 = 0, age1 = 0, age7 = 0;
  logic [31:0] dat0, dat1, dat7, junk;

  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_load) for (int i = 0; i < 256; i++) begin
      mem0[i] <= init_mem[i];
      mem1[i] <= init_mem[i];
      mem7[i] <= init_mem[i];
    end
    if (bus.mem_en && bus.mem_we) mem0[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) begin age0 <= 1; dat0 <= mem0[bus.mem_addr]; end
    else if (age0 != 0 && age0 < 50) age0 <= age0 + 1;
    if (b1.mem_en && !b1.mem_we) begin age1 <= 1; dat1 <= mem1[b1.mem_addr]; end
    else if (age1 != 0 && age1 < 50) age1 <= age1 + 1;
    if (b7.mem_en && !b7.mem_we) begin age7 <= 1; dat7 <= mem7[b7.mem_addr]; end
    else if (age7 != 0 && age7 < 50) age7 <= age7 + 1;
  end

  assign bus.mem_rdata = (age0 == L) ? dat0 : junk;
  assign b1.mem_rdata  = (age1 == 1) ? dat1 : junk;
  assign b7.mem_rdata  = (age7 == 7) ? dat7 : junk;

  // Round-robin arbiter model: priority rotates past the last granted core.
  logic [1:0] rr_ptr;
  logic [1:0] rr_idx;
  logic [2:0] gnt_auto;
  always_comb begin
    gnt_auto = '0;
    rr_idx   = '0;
    for (int k = 0; k < 3; k++) begin
      rr_idx = 2'((int'(rr_ptr) + k) % 3);
      if (gnt_auto == '0 && bus.arb_req[rr_idx]) gnt_auto[rr_idx] = 1'b1;
    end
  end
  always @(posedge clk) begin
    if (rst) rr_ptr <= 2'd0;
    else if (!use_force && gnt_auto != '0)
      rr_ptr <= gnt_auto[0] ? 2'd1 : (gnt_auto[1] ? 2'd2 : 2'd0);
  end
  assign bus.gnt_arb = use_force ? force_gnt : gnt_auto;
  assign b1.gnt_arb  = b1.arb_req;
  assign b7.gnt_arb  = b7.arb_req;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one transaction from core c in the current (IDLE) cycle, observes until ack,
  // then drops the request and steps into the following IDLE cycle.
  task automatic run_txn(input logic [1:0] c, input logic we, input logic [7:0] a,
                         input logic [31:0] d, output int en_cyc, output int ack_cyc,
                         output logic [2:0] ack_vec, output logic [31:0] rdata,
                         output logic we_seen, output logic [7:0] addr_seen,
                         output logic [31:0] wdata_seen, output int owner_bad,
                         output int busy_arb);
    en_cyc = -1; ack_cyc = -1; ack_vec = '0; rdata = '0;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0; owner_bad = 0; busy_arb = 0;
    bus.core_we[c] = we;
    bus.core_addr[c] = a;
    bus.core_wdata[c] = d;
    bus.core_req[c] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.mem_en && en_cyc < 0) begin
        en_cyc = t; we_seen = bus.mem_we; addr_seen = bus.mem_addr; wdata_seen = bus.mem_wdata;
      end
      if (bus.owner !== c) owner_bad++;
      if (bus.arb_req !== 3'b000) busy_arb++;
      if (bus.core_ack !== 3'b000) begin
        ack_cyc = t; ack_vec = bus.core_ack; rdata = bus.core_rdata;
        break;
      end
    end
    bus.core_req[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    tick();
    bus.core_req = 3'b101;
    #1;
    n_checks++; if (bus.arb_req !== 3'b101) begin n_errors++;
      $display("FAIL reset_arb_req: got %b expected %b", bus.arb_req, 3'b101); end
    n_checks++; if (bus.owner !== 2'd3) begin n_errors++;
      $display("FAIL reset_owner: got %0d expected 3", bus.owner); end
    n_checks++; if (bus.busy !== 1'b0 || bus.grant_err !== 1'b0) begin n_errors++;
      $display("FAIL reset_busy_err: got %b%b expected 00", bus.busy, bus.grant_err); end
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_errors++;
      $display("FAIL reset_mem_strobe: got %b%b expected 00", bus.mem_en, bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin n_errors++;
      $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
    n_checks++; if (bus.core_ack !== 3'b000 || bus.core_rdata !== 32'h0) begin n_errors++;
      $display("FAIL reset_ack_rdata: got %b/%h expected 000/0", bus.core_ack, bus.core_rdata); end
    bus.core_req = 3'b000;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin n_errors++;
      $display("FAIL idle_after_reset: got busy %b mem_en %b expected 0 0", bus.busy, bus.mem_en); end
    last_rd = 32'h0;
  endtask

  task automatic test_read_basic();
    int en_c, ack_c, ob, ba;
    logic [2:0] av; logic [31:0] rd, wd; logic ws; logic [7:0] as;
    run_txn(2'd1, 1'b0, 8'h10, 32'h0, en_c, ack_c, av, rd, ws, as, wd, ob, ba);
    n_checks++; if (en_c !== 1 || ws !== 1'b0 || as !== 8'h10) begin n_errors++;
      $display("FAIL read_access: got cyc %0d we %b addr %h expected 1 0 10", en_c, ws, as); end
    n_checks++; if (ack_c !== L + 2 || av !== 3'b010) begin n_errors++;
      $display("FAIL read_ack: got cyc %0d vec %b expected %0d 010", ack_c, av, L + 2); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++;
      $display("FAIL read_data: got %h expected deadbeef", rd); end
    n_checks++; if (ob !== 0 || ba !== 0) begin n_errors++;
      $display("FAIL read_owner_busy: got owner_bad %0d arb_busy %0d expected 0 0", ob, ba); end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_write();
    int en_c, ack_c, ob, ba;
    logic [2:0] av; logic [31:0] rd, wd; logic ws; logic [7:0] as;
    run_txn(2'd0, 1'b1, 8'h05, 32'h12345678, en_c, ack_c, av, rd, ws, as, wd, ob, ba);
    n_checks++; if (en_c !== 1 || ws !== 1'b1 || as !== 8'h05 || wd !== 32'h12345678) begin
      n_errors++;
      $display("FAIL write_access: got cyc %0d we %b addr %h data %h expected 1 1 05 12345678",
               en_c, ws, as, wd); end
    n_checks++; if (ack_c !== 2 || av !== 3'b001) begin n_errors++;
      $display("FAIL write_ack: got cyc %0d vec %b expected 2 001", ack_c, av); end
    n_checks++; if (rd !== last_rd) begin n_errors++;
      $display("FAIL write_rdata_hold: got %h expected %h", rd, last_rd); end
    n_checks++; if (bus.owner !== 2'd3 || bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL write_return_idle: got owner %0d busy %b expected 3 0", bus.owner, bus.busy); end
    ref_mem[8'h05] = 32'h12345678;
    run_txn(2'd2, 1'b0, 8'h05, 32'h0, en_c, ack_c, av, rd, ws, as, wd, ob, ba);
    n_checks++; if (ack_c !== L + 2 || rd !== 32'h12345678) begin n_errors++;
      $display("FAIL write_readback: got cyc %0d data %h expected %0d 12345678", ack_c, rd, L + 2); end
    last_rd = 32'h12345678;
  endtask

  task automatic test_random();
    int en_c, ack_c, ob, ba, exp_lat;
    logic [2:0] av; logic [31:0] rd, wd, d, exp_rd; logic ws, we; logic [7:0] as, a;
    logic [1:0] c;
    for (int n = 0; n < 24; n++) begin
      c  = 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = $urandom;
      exp_lat = we ? 2 : L + 2;
      exp_rd  = we ? last_rd : ref_mem[a];
      run_txn(c, we, a, d, en_c, ack_c, av, rd, ws, as, wd, ob, ba);
      n_checks++; if (ack_c !== exp_lat || av !== (3'b001 << c)) begin n_errors++;
        $display("FAIL rand_ack[%0d]: got cyc %0d vec %b expected %0d %b",
                 n, ack_c, av, exp_lat, 3'b001 << c); end
      n_checks++; if (rd !== exp_rd) begin n_errors++;
        $display("FAIL rand_rdata[%0d]: got %h expected %h", n, rd, exp_rd); end
      n_checks++; if (as !== a || ws !== we || (we && wd !== d)) begin n_errors++;
        $display("FAIL rand_mem[%0d]: got addr %h we %b wdata %h expected %h %b %h",
                 n, as, ws, wd, a, we, d); end
      n_checks++; if (ob !== 0) begin n_errors++;
        $display("FAIL rand_owner[%0d]: got %0d bad cycles expected 0", n, ob); end
      if (we) ref_mem[a] = d;
      else last_rd = exp_rd;
    end
  endtask

  task automatic test_round_robin();
    int acks = 0, prev_k = -1, prev_cyc = 0, k;
    for (int i = 0; i < 3; i++) bus.core_addr[i] = 8'($urandom_range(16, 255));
    bus.core_we = 3'b000;
    bus.core_req = 3'b111;
    for (int cyc = 1; cyc <= 80 && acks < 6; cyc++) begin
      tick();
      n_checks++; if (bus.busy && bus.arb_req !== 3'b000) begin n_errors++;
        $display("FAIL rr_arb_req_busy: got %b expected 000", bus.arb_req); end
      n_checks++; if (bus.grant_err !== 1'b0) begin n_errors++;
        $display("FAIL rr_grant_err: got 1 expected 0"); end
      if (bus.core_ack !== 3'b000) begin
        k = bus.core_ack[0] ? 0 : (bus.core_ack[1] ? 1 : 2);
        n_checks++; if (bus.core_rdata !== ref_mem[bus.core_addr[k]]) begin n_errors++;
          $display("FAIL rr_rdata: got %h expected %h", bus.core_rdata, ref_mem[bus.core_addr[k]]); end
        if (prev_k >= 0) begin
          n_checks++; if (k !== (prev_k + 1) % 3 || cyc - prev_cyc !== L + 3) begin n_errors++;
            $display("FAIL rr_order: got core %0d after %0d cycles expected core %0d after %0d",
                     k, cyc - prev_cyc, (prev_k + 1) % 3, L + 3); end
        end
        last_rd = ref_mem[bus.core_addr[k]];
        prev_k = k; prev_cyc = cyc; acks++;
        bus.core_addr[k] = 8'($urandom_range(16, 255));
      end
    end
    n_checks++; if (acks !== 6) begin n_errors++;
      $display("FAIL rr_ack_count: got %0d expected 6", acks); end
    bus.core_req = 3'b000;
    tick();
  endtask

  task automatic test_grant_err();
    logic [7:0] a1, a2;
    a1 = 8'($urandom_range(16, 127));
    a2 = 8'($urandom_range(128, 255));
    bus.core_we = 3'b000;
    bus.core_addr[1] = a1;
    bus.core_addr[2] = a2;
    use_force = 1'b1;
    force_gnt = 3'b110;
    bus.core_req = 3'b110;
    tick();
    force_gnt = 3'b000;
    n_checks++; if (bus.owner !== 2'd1 || bus.mem_en !== 1'b1 || bus.mem_addr !== a1) begin n_errors++;
      $display("FAIL multi_gnt_pick: got owner %0d en %b addr %h expected 1 1 %h",
               bus.owner, bus.mem_en, bus.mem_addr, a1); end
    n_checks++; if (bus.grant_err !== 1'b1) begin n_errors++;
      $display("FAIL multi_gnt_err: got %b expected 1", bus.grant_err); end
    tick();
    n_checks++; if (bus.grant_err !== 1'b0) begin n_errors++;
      $display("FAIL multi_gnt_err_once: got %b expected 0", bus.grant_err); end
    force_gnt = 3'b001;
    tick();
    force_gnt = 3'b000;
    n_checks++; if (bus.grant_err !== 1'b1 || bus.owner !== 2'd1 || bus.busy !== 1'b1) begin n_errors++;
      $display("FAIL wait_gnt_err: got err %b owner %0d busy %b expected 1 1 1",
               bus.grant_err, bus.owner, bus.busy); end
    tick();
    n_checks++; if (bus.core_ack !== 3'b010 || bus.core_rdata !== ref_mem[a1]) begin n_errors++;
      $display("FAIL wait_gnt_txn: got ack %b data %h expected 010 %h",
               bus.core_ack, bus.core_rdata, ref_mem[a1]); end
    bus.core_req[1] = 1'b0;
    use_force = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (bus.core_ack !== 3'b000) break;
    end
    n_checks++; if (bus.core_ack !== 3'b100 || bus.core_rdata !== ref_mem[a2]) begin n_errors++;
      $display("FAIL pending_core2: got ack %b data %h expected 100 %h",
               bus.core_ack, bus.core_rdata, ref_mem[a2]); end
    bus.core_req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    int en_c, ack_c, ob, ba;
    logic [2:0] av; logic [31:0] rd, wd; logic ws; logic [7:0] as, a;
    logic [2:0] ack_seen;
    a = 8'($urandom_range(16, 255));
    bus.core_we[2] = 1'b0;
    bus.core_addr[2] = a;
    bus.core_req[2] = 1'b1;
    tick();
    ack_seen = bus.core_ack;
    tick();
    ack_seen = ack_seen | bus.core_ack;
    rst = 1'b1;
    tick();
    ack_seen = ack_seen | bus.core_ack;
    n_checks++; if (bus.busy !== 1'b0 || bus.owner !== 2'd3 || bus.mem_en !== 1'b0) begin n_errors++;
      $display("FAIL rst_mid_state: got busy %b owner %0d en %b expected 0 3 0",
               bus.busy, bus.owner, bus.mem_en); end
    n_checks++; if (ack_seen !== 3'b000 || bus.core_rdata !== 32'h0 || bus.mem_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got ack %b rdata %h addr %h expected 000 0 00",
               ack_seen, bus.core_rdata, bus.mem_addr); end
    rst = 1'b0;
    last_rd = 32'h0;
    run_txn(2'd2, 1'b0, a, 32'h0, en_c, ack_c, av, rd, ws, as, wd, ob, ba);
    n_checks++; if (ack_c !== L + 2 || av !== 3'b100 || rd !== ref_mem[a]) begin n_errors++;
      $display("FAIL rst_reissue: got cyc %0d vec %b data %h expected %0d 100 %h",
               ack_c, av, rd, L + 2, ref_mem[a]); end
    last_rd = ref_mem[a];
  endtask

  task automatic test_latency();
    int ack1 = -1, ack7 = -1;
    logic [2:0] v1 = '0, v7 = '0;
    logic [31:0] r1 = '0, r7 = '0;
    logic [7:0] a1, a7;
    a1 = 8'($urandom_range(16, 255));
    a7 = 8'($urandom_range(16, 255));
    b1.core_addr[0] = a1;
    b7.core_addr[2] = a7;
    b1.core_req = 3'b001;
    b7.core_req = 3'b100;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (b1.core_ack !== 3'b000 && ack1 < 0) begin
        ack1 = t; v1 = b1.core_ack; r1 = b1.core_rdata; b1.core_req = 3'b000; end
      if (b7.core_ack !== 3'b000 && ack7 < 0) begin
        ack7 = t; v7 = b7.core_ack; r7 = b7.core_rdata; b7.core_req = 3'b000; end
    end
    n_checks++; if (ack1 !== 3 || v1 !== 3'b001 || r1 !== init_mem[a1]) begin n_errors++;
      $display("FAIL lat1_read: got cyc %0d vec %b data %h expected 3 001 %h", ack1, v1, r1, init_mem[a1]); end
    n_checks++; if (ack7 !== 9 || v7 !== 3'b100 || r7 !== init_mem[a7]) begin n_errors++;
      $display("FAIL lat7_read: got cyc %0d vec %b data %h expected 9 100 %h", ack7, v7, r7, init_mem[a7]); end
  endtask

  initial begin
    rst = 1'b1;
    mem_load = 1'b0;
    use_force = 1'b0;
    force_gnt = 3'b000;
    last_rd = 32'h0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10]  = 32'hDEADBEEF;
    bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
    b1.core_req  = '0; b1.core_we  = '0; b1.core_addr  = '0; b1.core_wdata  = '0;
    b7.core_req  = '0; b7.core_we  = '0; b7.core_addr  = '0; b7.core_wdata  = '0;

    test_reset();
    test_read_basic();
    test_write();
    test_random();
    test_round_robin();
    test_grant_err();
    test_reset_mid();
    test_latency();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
